conway_engine: RTL and testbench

CONWAY_ENGINE -- requirements
Module: conway_engine

---
 rtl/conway_pkg.sv | 17 +
 rtl/conway_row_next.sv | 49 ++++
 rtl/conway_engine.sv | 166 ++++++++++++++++
 tb/tb_conway_engine.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conway_pkg.sv
// Shared board defaults, FSM state encoding and default life-rule masks
// for the conway_engine block.
package conway_pkg;

  localparam int MAX_X_DEF = 32;
  localparam int MAX_Y_DEF = 24;

  localparam logic [8:0] BIRTH_B3    = 9'h008;
  localparam logic [8:0] SURVIVE_S23 = 9'h00C;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COMPUTE = 2'd1,
    ST_COMMIT  = 2'd2
  } conway_state_t;

endpackage

// File: rtl/conway_row_next.sv
// Combinational next-generation row: three board rows plus rule masks in,
// next row and its live-cell count out. Horizontal wrap when CONWAY_TOROID_EN.
module conway_row_next
  import conway_pkg::*;
#(
  parameter int MAX_X = MAX_X_DEF
)(
  input  logic [MAX_X-1:0] row_above,
  input  logic [MAX_X-1:0] row_cur,
  input  logic [MAX_X-1:0] row_below,
  input  logic [8:0]       birth_mask,
  input  logic [8:0]       survive_mask,
  output logic [MAX_X-1:0] row_next,
  output logic [8:0]       row_pop
);

  // ext[x+1] is cell x; ext[0] and ext[MAX_X+1] are the off-board columns
  logic [MAX_X+1:0] above_ext;
  logic [MAX_X+1:0] cur_ext;
  logic [MAX_X+1:0] below_ext;
  logic [3:0]       nbr;

`ifdef CONWAY_TOROID_EN
  assign above_ext = {row_above[0], row_above, row_above[MAX_X-1]};
  assign cur_ext   = {row_cur[0],   row_cur,   row_cur[MAX_X-1]};
  assign below_ext = {row_below[0], row_below, row_below[MAX_X-1]};
`else
  assign above_ext = {1'b0, row_above, 1'b0};
  assign cur_ext   = {1'b0, row_cur,   1'b0};
  assign below_ext = {1'b0, row_below, 1'b0};
`endif

  function automatic logic [3:0] pop3(input logic [2:0] w);
    return {3'b000, w[0]} + {3'b000, w[1]} + {3'b000, w[2]};
  endfunction

  always_comb begin
    row_next = '0;
    row_pop  = '0;
    nbr      = '0;
    for (int x = 0; x < MAX_X; x++) begin
      nbr = pop3(above_ext[x +: 3]) + pop3(below_ext[x +: 3])
          + {3'b000, cur_ext[x]} + {3'b000, cur_ext[x+2]};
      row_next[x] = row_cur[x] ? survive_mask[nbr] : birth_mask[nbr];
      row_pop = row_pop + {8'd0, row_next[x]};
    end
  end

endmodule

// File: rtl/conway_engine.sv
// Game-of-life engine: one board row per cycle into a shadow buffer, then an
// atomic commit. Board edges wrap when CONWAY_TOROID_EN is defined.
//
//   state      | meaning
//   ST_IDLE    | board stable; accepts draw (priority) or step
//   ST_COMPUTE | row_cnt selects the row being written to shadow
//   ST_COMMIT  | shadow copied to state, generation bumped, done pulsed
module conway_engine
  import conway_pkg::*;
#(
  parameter int MAX_X = MAX_X_DEF,
  parameter int MAX_Y = MAX_Y_DEF
)(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   step,
  input  logic                   freeze,
  input  logic                   draw,
  input  logic [7:0]             cursor_x,
  input  logic [7:0]             cursor_y,
  input  logic [63:0]            pattern_mat,
  input  logic [8:0]             birth_mask,
  input  logic [8:0]             survive_mask,
  output logic [MAX_X*MAX_Y-1:0] state,
  output logic [11:0]            alives,
  output logic [15:0]            generation,
  output logic                   busy,
  output logic                   done
);

  localparam int NCELL = MAX_X * MAX_Y;
  localparam int IDXW  = (NCELL > 1) ? $clog2(NCELL) : 1;

`ifdef CONWAY_TOROID_EN
  localparam logic WRAP = 1'b1;
`else
  localparam logic WRAP = 1'b0;
`endif

  if (NCELL > 4095 || MAX_X > 256 || MAX_Y > 256 || MAX_X < 1 || MAX_Y < 1) begin : g_bad_size
    $error("conway_engine: board size out of range");
  end

  conway_state_t    fsm_q, fsm_d;
  logic [7:0]       row_cnt;
  logic [11:0]      pop_acc;
  logic [NCELL-1:0] shadow;
  logic [NCELL-1:0] stamp;
  logic [11:0]      new_cnt;
  logic             do_start, do_draw, do_row, do_commit, last_row;

  logic [IDXW-1:0]  cur_base, above_base, below_base;
  logic [MAX_X-1:0] row_above, row_cur, row_below, row_nxt;
  logic [8:0]       row_pop;
  int               sx, sy;

  assign last_row = (row_cnt == 8'(MAX_Y - 1));
  assign busy     = (fsm_q != ST_IDLE);

  always_comb begin
    fsm_d     = fsm_q;
    do_start  = 1'b0;
    do_draw   = 1'b0;
    do_row    = 1'b0;
    do_commit = 1'b0;
    unique case (fsm_q)
      ST_IDLE: begin
        if (draw) begin
          do_draw = 1'b1;
        end else if (step && !freeze) begin
          do_start = 1'b1;
          fsm_d    = ST_COMPUTE;
        end
      end
      ST_COMPUTE: begin
        do_row = 1'b1;
        if (last_row) fsm_d = ST_COMMIT;
      end
      ST_COMMIT: begin
        do_commit = 1'b1;
        fsm_d     = ST_IDLE;
      end
      default: fsm_d = ST_IDLE;
    endcase
  end

  // Neighbour rows always come from the committed board, never the shadow
  always_comb begin
    cur_base   = IDXW'(int'(row_cnt) * MAX_X);
    above_base = (row_cnt == '0) ? IDXW'((MAX_Y - 1) * MAX_X)
                                 : IDXW'((int'(row_cnt) - 1) * MAX_X);
    below_base = last_row ? '0 : IDXW'((int'(row_cnt) + 1) * MAX_X);
    row_cur    = state[cur_base +: MAX_X];
    row_above  = (row_cnt != '0 || WRAP) ? state[above_base +: MAX_X] : '0;
    row_below  = (!last_row || WRAP) ? state[below_base +: MAX_X] : '0;
  end

  conway_row_next #(.MAX_X(MAX_X)) u_row_next (
    .row_above    (row_above),
    .row_cur      (row_cur),
    .row_below    (row_below),
    .birth_mask   (birth_mask),
    .survive_mask (survive_mask),
    .row_next     (row_nxt),
    .row_pop      (row_pop)
  );

  always_comb begin
    stamp = '0;
    sx    = 0;
    sy    = 0;
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 8; c++) begin
        sx = int'(cursor_x) + c;
        sy = int'(cursor_y) + r;
        if (WRAP) begin
          sx = sx % MAX_X;
          sy = sy % MAX_Y;
        end
        if (pattern_mat[r*8 + c] && sx < MAX_X && sy < MAX_Y)
          stamp[IDXW'(sy * MAX_X + sx)] = 1'b1;
      end
    end
  end

  // Only cells that actually turn on add to the live count
  assign new_cnt = 12'($countones(stamp & ~state));

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q      <= ST_IDLE;
      row_cnt    <= '0;
      pop_acc    <= '0;
      state      <= '0;
      alives     <= '0;
      generation <= '0;
      done       <= 1'b0;
    end else begin
      fsm_q <= fsm_d;
      done  <= 1'b0;
      if (do_start) begin
        row_cnt <= '0;
        pop_acc <= '0;
      end
      if (do_row) begin
        row_cnt <= last_row ? '0 : row_cnt + 8'd1;
        pop_acc <= pop_acc + 12'(row_pop);
      end
      if (do_draw) begin
        state  <= state | stamp;
        alives <= alives + new_cnt;
      end
      if (do_commit) begin
        state      <= shadow;
        alives     <= pop_acc;
        generation <= generation + 16'd1;
        done       <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (do_row) shadow[cur_base +: MAX_X] <= row_nxt;
  end

endmodule

// File: tb/tb_conway_engine.sv
// Self-checking bench for conway_engine: draw vector table, hand sequences for
// latency/reset/freeze corners, and randomized boards against a cell-level model.
module tb_conway_engine;
  import conway_pkg::*;

  localparam int MX = 32;
  localparam int MY = 24;
  localparam int NC = MX * MY;
`ifdef CONWAY_TOROID_EN
  localparam bit TOR = 1'b1;
`else
  localparam bit TOR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst, step, freeze, draw;
  logic [7:0]    cursor_x, cursor_y;
  logic [63:0]   pattern_mat;
  logic [8:0]    birth_mask, survive_mask;
  logic [NC-1:0] state;
  logic [11:0]   alives;
  logic [15:0]   generation;
  logic          busy, done;

  conway_engine #(.MAX_X(MX), .MAX_Y(MY)) dut (
    .clk          (clk),
    .rst          (rst),
    .step         (step),
    .freeze       (freeze),
    .draw         (draw),
    .cursor_x     (cursor_x),
    .cursor_y     (cursor_y),
    .pattern_mat  (pattern_mat),
    .birth_mask   (birth_mask),
    .survive_mask (survive_mask),
    .state        (state),
    .alives       (alives),
    .generation   (generation),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  int            n_cmp = 0;
  int            n_bad = 0;
  logic [NC-1:0] mdl;
  logic [15:0]   mgen;

  typedef struct {
    logic [7:0]  cx;
    logic [7:0]  cy;
    logic [63:0] pat;
    int          exp_alives;
  } draw_vec_t;

  draw_vec_t vecs [7];

  function automatic int wrapm(input int v, input int m);
    return ((v % m) + m) % m;
  endfunction

  function automatic logic [NC-1:0] put(input logic [NC-1:0] b, input int x, input int y);
    b[y*MX + x] = 1'b1;
    return b;
  endfunction

  function automatic logic [NC-1:0] mdl_next(input logic [NC-1:0] b, input logic [8:0] bm,
                                             input logic [8:0] sm);
    logic [NC-1:0] r;
    int n, xx, yy;
    r = '0;
    for (int y = 0; y < MY; y++)
      for (int x = 0; x < MX; x++) begin
        n = 0;
        for (int dy = -1; dy <= 1; dy++)
          for (int dx = -1; dx <= 1; dx++)
            if (dx != 0 || dy != 0) begin
              xx = x + dx;
              yy = y + dy;
              if (TOR) begin
                xx = wrapm(xx, MX);
                yy = wrapm(yy, MY);
              end
              if (xx >= 0 && xx < MX && yy >= 0 && yy < MY) n += int'(b[yy*MX + xx]);
            end
        r[y*MX + x] = b[y*MX + x] ? sm[n] : bm[n];
      end
    return r;
  endfunction

  function automatic logic [NC-1:0] mdl_draw(input logic [NC-1:0] b, input int cx, input int cy,
                                             input logic [63:0] pat);
    int x, y;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        if (pat[r*8 + c]) begin
          x = cx + c;
          y = cy + r;
          if (TOR) begin
            x = x % MX;
            y = y % MY;
          end
          if (x < MX && y < MY) b[y*MX + x] = 1'b1;
        end
    return b;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_board(input string nm, input logic [NC-1:0] act, input logic [NC-1:0] exp);
    int idx;
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      idx = 0;
      for (int i = NC - 1; i >= 0; i--) if (act[i] !== exp[i]) idx = i;
      $display("FAIL %s: first differing cell (%0d,%0d) got %0d live expected %0d live",
               nm, idx % MX, idx / MX, $countones(act), $countones(exp));
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; step = 1'b0; draw = 1'b0; freeze = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    mdl = '0;
    mgen = '0;
  endtask

  task automatic do_draw(input int cx, input int cy, input logic [63:0] pat);
    @(negedge clk);
    cursor_x = 8'(cx); cursor_y = 8'(cy); pattern_mat = pat; draw = 1'b1;
    @(negedge clk);
    draw = 1'b0;
    mdl = mdl_draw(mdl, cx, cy, pat);
    chk_board("draw_state", state, mdl);
    chk("draw_alives", alives, $countones(mdl));
    chk("draw_gen", generation, mgen);
  endtask

  // disturb: mid-compute step+draw pulse and freeze rise, all of which must be ignored
  task automatic do_step(input logic [8:0] bm, input logic [8:0] sm, input bit disturb);
    logic [NC-1:0] pre;
    int cnt;
    pre = mdl;
    @(negedge clk);
    birth_mask = bm; survive_mask = sm; step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    chk("step_busy", busy, 1);
    cnt = 0;
    while (!done && cnt < MY + 10) begin
      @(negedge clk);
      cnt++;
      if (disturb && cnt == 5) begin
        step = 1'b1; draw = 1'b1; pattern_mat = '1; cursor_x = 8'd0; cursor_y = 8'd0;
      end else if (disturb && cnt == 6) begin
        step = 1'b0; draw = 1'b0; freeze = 1'b1;
      end
      if (cnt == MY / 2) chk_board("compute_stable", state, pre);
    end
    chk("step_latency", cnt, MY + 1);
    mdl = mdl_next(pre, bm, sm);
    mgen++;
    chk_board("step_state", state, mdl);
    chk("step_alives", alives, $countones(mdl));
    chk("step_gen", generation, mgen);
    @(negedge clk);
    freeze = 1'b0;
    chk("done_pulse_width", done, 0);
    chk("idle_after_commit", busy, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NC-1:0] exp_b;
    int seen;
    rst = 1'b1; step = 1'b0; freeze = 1'b0; draw = 1'b0;
    cursor_x = '0; cursor_y = '0; pattern_mat = '0;
    birth_mask = BIRTH_B3; survive_mask = SURVIVE_S23;
    mdl = '0; mgen = '0;

    do_reset();
    chk_board("rst_state", state, '0);
    chk("rst_alives", alives, 0);
    chk("rst_gen", generation, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);

    vecs[0] = '{8'd0,   8'd0,   64'h1, 1};
    vecs[1] = '{8'd0,   8'd0,   '1,    64};
    vecs[2] = '{8'd28,  8'd20,  '1,    TOR ? 64 : 16};
    vecs[3] = '{8'd31,  8'd23,  '1,    TOR ? 64 : 1};
    vecs[4] = '{8'd100, 8'd100, 64'hFF, TOR ? 8 : 0};
    vecs[5] = '{8'd5,   8'd5,   64'h8100_0000_0000_0081, 4};
    vecs[6] = '{8'd30,  8'd0,   64'h0303, 4};
    for (int i = 0; i < 7; i++) begin
      do_reset();
      do_draw(vecs[i].cx, vecs[i].cy, vecs[i].pat);
      chk($sformatf("vec%0d_alives", i), alives, vecs[i].exp_alives);
      chk($sformatf("vec%0d_done", i), done, 0);
    end

    // redraw of already-live cells must not inflate the count
    do_reset();
    do_draw(2, 2, '1);
    do_draw(4, 4, '1);
    chk("overlap_alives", alives, 64 + 28);

    // blinker
    do_reset();
    do_draw(10, 5, 64'h7);
    do_step(BIRTH_B3, SURVIVE_S23, 1'b0);
    exp_b = put(put(put('0, 11, 4), 11, 5), 11, 6);
    chk_board("blinker_vertical", state, exp_b);
    chk("blinker_alives", alives, 3);

    // still-life block, with one disturbed step
    do_reset();
    do_draw(0, 0, 64'h0303);
    for (int i = 0; i < 10; i++) do_step(BIRTH_B3, SURVIVE_S23, i == 3);
    exp_b = put(put(put(put('0, 0, 0), 1, 0), 0, 1), 1, 1);
    chk_board("block_state", state, exp_b);
    chk("block_alives", alives, 4);
    chk("block_gen", generation, 10);

    // glider into the bottom-right corner
    do_reset();
    do_draw(29, 21, 64'h0007_0402);
    for (int i = 0; i < 4; i++) do_step(BIRTH_B3, SURVIVE_S23, 1'b0);
    if (TOR) begin
      exp_b = put(put(put(put(put('0, 31, 22), 0, 23), 30, 0), 31, 0), 0, 0);
      chk_board("glider_wrapped", state, exp_b);
      chk("glider_alives", alives, 5);
    end else begin
      chk("glider_clipped_alives", alives, 4);
      do_step(BIRTH_B3, SURVIVE_S23, 1'b0);
      chk("glider_stable_alives", alives, 4);
    end

    // all-zero masks kill everything
    do_reset();
    do_draw(3, 3, 64'h00FF_1234_5678_9ABC);
    do_step(9'h000, 9'h000, 1'b0);
    chk_board("zero_mask_state", state, '0);
    chk("zero_mask_alives", alives, 0);

    // draw and step in the same cycle: draw wins, step dropped
    do_reset();
    @(negedge clk);
    cursor_x = 8'd8; cursor_y = 8'd8; pattern_mat = 64'h3C; draw = 1'b1; step = 1'b1;
    @(negedge clk);
    draw = 1'b0; step = 1'b0;
    mdl = mdl_draw(mdl, 8, 8, 64'h3C);
    chk("drawstep_busy", busy, 0);
    chk_board("drawstep_state", state, mdl);
    @(negedge clk);
    chk("drawstep_not_queued", busy, 0);
    chk("drawstep_gen", generation, 0);

    // freeze blocks step but not draw
    @(negedge clk);
    freeze = 1'b1; step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    chk("freeze_blocks_step", busy, 0);
    do_draw(20, 1, 64'h0101);
    chk("freeze_draw_alives", alives, 6);
    freeze = 1'b0;

    // reset while computing row 7
    do_reset();
    do_draw(12, 12, 64'h0707);
    @(negedge clk);
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    repeat (7) @(negedge clk);
    chk("pre_abort_busy", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    mdl = '0; mgen = '0;
    chk_board("abort_state", state, '0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_alives", alives, 0);
    seen = 0;
    for (int i = 0; i < MY + 4; i++) begin
      @(negedge clk);
      if (done || busy) seen++;
    end
    chk("abort_no_done", seen, 0);
    freeze = 1'b1; step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    @(negedge clk);
    chk("abort_freeze_step", busy, 0);
    freeze = 1'b0;

    // randomized boards and rules
    for (int rnd = 0; rnd < 6; rnd++) begin
      logic [8:0] bm, sm;
      do_reset();
      for (int k = 0; k < 4; k++)
        do_draw($urandom_range(0, 39), $urandom_range(0, 31),
                {$urandom, $urandom} & {$urandom, $urandom});
      for (int k = 0; k < 3; k++) begin
        bm = (rnd % 2 == 0) ? BIRTH_B3    : 9'($urandom_range(0, 511));
        sm = (rnd % 2 == 0) ? SURVIVE_S23 : 9'($urandom_range(0, 511));
        do_step(bm, sm, 1'b0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
